// File: rtl/apb_master_ctrl.sv
// APB requester: takes one command at a time, runs SETUP/ACCESS with
// wait-state and timeout handling, and returns a response on a valid/ready port.
module apb_master_ctrl #(
  parameter int ADDR    = 10,
  parameter int DATA    = 8,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 16
) (
  input  logic            pclk,
  input  logic            preset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_write,
  input  logic [ADDR-1:0] cmd_addr,
  input  logic [DATA-1:0] cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_write,
  output logic [DATA-1:0] rsp_rdata,
  output logic            rsp_timeout,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [ADDR-1:0] paddr,
  output logic [DATA-1:0] pwdata,
  input  logic [DATA-1:0] prdata,
  input  logic            pready,
  output logic            busy
);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, RDWAIT, RESP} state_t;

  // Counter is kept 1 bit wide when the timeout is disabled.
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]    LAT_LAST  = 2'((RD_LAT > 0) ? RD_LAT - 1 : 0);

  state_t        state, nxt;
  logic [WW-1:0] wait_cnt;
  logic [1:0]    lat_cnt;
  logic          load_cmd, cap_rd, abort, wait_inc, lat_inc;

  // State register
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) state <= IDLE;
    else           state <= nxt;
  end

  // Next-state and per-cycle control decisions
  always_comb begin
    nxt      = state;
    load_cmd = 1'b0;
    cap_rd   = 1'b0;
    abort    = 1'b0;
    wait_inc = 1'b0;
    lat_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          load_cmd = 1'b1;
          nxt      = SETUP;
        end
      end
      SETUP: nxt = ACCESS;
      ACCESS: begin
        if (pready) begin
          if (pwrite)          nxt = RESP;
          else if (RD_LAT > 0) nxt = RDWAIT;
          else begin
            cap_rd = 1'b1;
            nxt    = RESP;
          end
        end else if (TIMEOUT > 0 && wait_cnt == WAIT_LAST) begin
          abort = 1'b1;
          nxt   = RESP;
        end else begin
          wait_inc = (TIMEOUT > 0);
        end
      end
      RDWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          cap_rd = 1'b1;
          nxt    = RESP;
        end else begin
          lat_inc = 1'b1;
        end
      end
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Wait-state and read-latency counters, cleared on entry to their state
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wait_cnt <= '0;
      lat_cnt  <= '0;
    end else begin
      if (state == SETUP)  wait_cnt <= '0;
      else if (wait_inc)   wait_cnt <= wait_cnt + 1'b1;
      if (state == ACCESS) lat_cnt <= '0;
      else if (lat_inc)    lat_cnt <= lat_cnt + 1'b1;
    end
  end

  // Command registers drive the APB bus; response fields load on entry to RESP
  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      if (load_cmd) begin
        pwrite <= cmd_write;
        paddr  <= cmd_addr;
        pwdata <= cmd_wdata;
      end
      if (nxt == RESP && state != RESP) begin
        rsp_write   <= pwrite;
        rsp_timeout <= abort;
        rsp_rdata   <= cap_rd ? prdata : '0;
      end
    end
  end

  // Handshake and bus-phase outputs decode straight from state
  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    psel      = (state == SETUP) || (state == ACCESS);
    penable   = (state == ACCESS);
    rsp_valid = (state == RESP);
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: behavioural APB slave plus a transaction-level
// reference (expected latency, read data and memory contents per command).
module tb_apb_master_ctrl;

  localparam int unsigned TO  = 4;
  localparam int unsigned RDL = 1;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [9:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [9:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       pready, busy;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  apb_master_ctrl #(.ADDR(10), .DATA(8), .RD_LAT(RDL), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset_n(preset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .busy(busy)
  );

  always #5 pclk = ~pclk;

  // Slave: contents reset to index, registered prdata, pready low for wait_n ACCESS cycles
  logic [7:0]  smem [1024];
  int unsigned acc_cnt;
  int unsigned wait_n = 0;
  assign pready = (acc_cnt >= wait_n);

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      for (int unsigned i = 0; i < 1024; i++) smem[i] <= 8'(i);
      prdata  <= '0;
      acc_cnt <= 0;
    end else if (psel && penable) begin
      if (pready) begin
        acc_cnt <= 0;
        if (pwrite) smem[paddr] <= pwdata;
        else        prdata      <= smem[paddr];
      end else begin
        acc_cnt <= acc_cnt + 1;
      end
    end else begin
      acc_cnt <= 0;
    end
  end

  // Reference memory image
  logic [7:0] ref_mem [1024];

  task automatic ref_reset();
    for (int unsigned i = 0; i < 1024; i++) ref_mem[i] = 8'(i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic run_txn(input logic wr, input logic [9:0] a, input logic [7:0] d,
                         input int unsigned waits, input int unsigned hold);
    logic        to;
    logic [7:0]  exp_rd;
    int unsigned exp_lat, n;
    bit          seen;
    to      = (waits >= TO);
    exp_lat = to ? TO + 2 : 3 + waits + (wr ? 0 : RDL);
    exp_rd  = (to || wr) ? 8'h00 : ref_mem[a];
    if (!to && wr) ref_mem[a] = d;
    wait_n = waits;

    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
    cmd_write = ~wr; cmd_addr = 10'($urandom); cmd_wdata = 8'($urandom);
    check("setup_phase", {psel, penable}, 2'b10);

    n = 1; seen = 0;
    while (!seen && n < 20) begin
      if (rsp_valid) seen = 1;
      else begin
        if (n == 2) check("access_phase", {psel, penable}, 2'b11);
        if (penable) check("access_hold", {pwrite, paddr, pwdata}, {wr, a, d});
        @(posedge pclk); @(negedge pclk);
        n++;
      end
    end
    check("latency", n, exp_lat);
    check("rsp_fields", {rsp_write, rsp_timeout, rsp_rdata, busy, cmd_ready},
          {wr, to, exp_rd, 1'b1, 1'b0});

    rsp_ready = 1'b0;
    for (int unsigned k = 0; k < hold; k++) begin
      @(posedge pclk); @(negedge pclk);
      check("rsp_hold", {rsp_valid, cmd_ready, rsp_write, rsp_timeout, rsp_rdata},
            {1'b1, 1'b0, wr, to, exp_rd});
    end
    rsp_ready = 1'b1;
    @(posedge pclk); @(negedge pclk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, busy, cmd_ready}, 3'b001);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    preset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; rsp_ready = 1'b0;
    ref_reset();
    repeat (3) @(negedge pclk);
    check("reset_ctrl", {cmd_ready, psel, penable, pwrite, rsp_valid, rsp_write, rsp_timeout, busy},
          8'b1000_0000);
    check("reset_data", {paddr, pwdata, rsp_rdata}, 26'd0);
    preset_n = 1'b1;

    // Directed: write, read-back, wait states, held response, timeout
    run_txn(1'b1, 10'h005, 8'hA5, 0, 0);
    check("slave_mem5", smem[5], 8'hA5);
    run_txn(1'b0, 10'h005, 8'h00, 0, 0);
    run_txn(1'b1, 10'h00C, 8'h3C, 3, 0);
    run_txn(1'b0, 10'h00C, 8'h11, 3, 5);
    run_txn(1'b0, 10'h007, 8'h00, 50, 1);
    run_txn(1'b1, 10'h008, 8'hFF, 50, 0);
    run_txn(1'b0, 10'h008, 8'h00, 0, 0);

    // Random traffic over a small address window so reads hit earlier writes
    for (int unsigned t = 0; t < 40; t++)
      run_txn(1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), 8'($urandom),
              $urandom_range(0, 5), $urandom_range(0, 2));

    // Reset in the middle of ACCESS drops the transfer
    wait_n = 3;
    @(negedge pclk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h002;
    @(posedge pclk); @(negedge pclk);
    cmd_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    check("pre_reset_access", {psel, penable}, 2'b11);
    preset_n = 1'b0;
    #1;
    check("async_reset", {psel, penable, rsp_valid, cmd_ready, busy}, 5'b00010);
    ref_reset();
    @(negedge pclk);
    preset_n = 1'b1;

    // Fresh slave contents equal the index
    run_txn(1'b0, 10'h003, 8'h00, 0, 0);
    run_txn(1'b0, 10'h005, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
